// File: rtl/cache_pkg.sv
// Shared types and helpers for the N-way cache controller.
// Build option: CACHE_PERF_CNT_EN (consumed by cache_ctrl_nway).
package cache_pkg;

   localparam int MAX_WAYS = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WB,
      FILL,
      ERROR
   } state_t;

   typedef enum logic {
      OP_READ,
      OP_WRITE
   } op_t;

   // Index of the set bit of a one-hot vector (0 when no bit is set).
   // Callers must screen out multi-hot inputs first.
   function automatic int unsigned onehot_to_idx(input logic [MAX_WAYS-1:0] oh);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < MAX_WAYS; i++) begin
         if (oh[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim picker: lowest-index invalid way first, otherwise the
// replacement policy's choice. Purely combinational; the FSM latches it.
module cache_victim_sel
   import cache_pkg::*;
#(
   parameter int WAYS  = 2,
   parameter int WAY_W = $clog2(WAYS)
) (
   input  logic [WAYS-1:0]  is_valid,
   input  logic [WAY_W-1:0] lru_victim,
   output logic [WAY_W-1:0] victim
);

   // Scan from the top so the lowest-index invalid way is the last one written.
   always_comb begin
      // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
      victim = lru_victim;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!is_valid[i]) victim = WAY_W'(i);
      end
   end

endmodule

// File: rtl/cache_ctrl_nway.sv
// N-way write-back, write-allocate cache controller FSM.
// State, latched victim, op and beat counter live in one register block;
// every output is decoded from that registered state (plus mem_ack/hit_way
// for the strobes that must coincide with the array/memory beat).
// Build option: CACHE_PERF_CNT_EN adds hit/miss/write-back counters.
module cache_ctrl_nway
   import cache_pkg::*;
#(
   parameter int WAYS       = 2,
   parameter int LINE_BEATS = 4,
   parameter int BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_read,
   input  logic                     cpu_write,
   input  logic [WAYS-1:0]          hit_way,
   input  logic [WAYS-1:0]          is_valid,
   input  logic [WAYS-1:0]          is_dirty,
   input  logic [$clog2(WAYS)-1:0]  lru_victim,
   input  logic                     mem_ack,
   input  logic                     mem_err,
   output logic                     cpu_mem_valid,
   output logic                     cpu_err,
   output logic                     lru_load,
   output logic [$clog2(WAYS)-1:0]  way_sel,
   output logic [WAYS-1:0]          load_tag,
   output logic [WAYS-1:0]          load_line,
   output logic [WAYS-1:0]          load_bytes,
   output logic [WAYS-1:0]          set_valid,
   output logic [WAYS-1:0]          write_valid,
   output logic [WAYS-1:0]          set_dirty,
   output logic [WAYS-1:0]          write_dirty,
   output logic                     mem_read,
   output logic                     mem_write,
`ifdef CACHE_PERF_CNT_EN
   output logic [31:0]              hit_cnt,
   output logic [31:0]              miss_cnt,
   output logic [31:0]              wb_cnt,
`endif
   output logic [BEAT_W-1:0]        beat_idx
);

   localparam int WAY_W = $clog2(WAYS);

   state_t              state;
   op_t                 op;
   logic [WAY_W-1:0]    victim_q;
   logic [BEAT_W-1:0]   beat_cnt;
   logic                replay;

   logic [WAY_W-1:0]    victim_pick;
   logic                victim_dirty;
   logic                any_hit;
   logic                multi_hit;
   logic                single_hit;
   logic                last_beat;
   logic [WAY_W-1:0]    hit_idx;
   logic [MAX_WAYS-1:0] hit_ext;
   logic [WAYS-1:0]     victim_oh;

   cache_victim_sel #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_victim_sel (
      .is_valid   (is_valid),
      .lru_victim (lru_victim),
      .victim     (victim_pick)
   );

   assign any_hit      = |hit_way;
   assign multi_hit    = $countones(hit_way) > 1;
   assign single_hit   = any_hit && !multi_hit;
   assign victim_dirty = is_valid[victim_pick] && is_dirty[victim_pick];
   assign last_beat    = (beat_cnt == BEAT_W'(LINE_BEATS - 1));
   assign victim_oh    = WAYS'(1) << victim_q;

   // Encode the (screened) one-hot hit vector into a way index.
   always_comb begin
      hit_ext             = '0;
      hit_ext[WAYS-1:0]   = hit_way;
      hit_idx             = WAY_W'(onehot_to_idx(hit_ext));
   end

   // Controller state: request capture, hit/miss resolution, beat counting.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
      if (rst) begin
         state    <= IDLE;
         op       <= OP_READ;
         victim_q <= '0;
         beat_cnt <= '0;
         replay   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               replay <= 1'b0;
               if (cpu_write || cpu_read) begin
                  op    <= cpu_write ? OP_WRITE : OP_READ;
                  state <= LOOKUP;
               end
            end
            LOOKUP: begin
               beat_cnt <= '0;
               replay   <= 1'b0;
               if (multi_hit) begin
                  state <= ERROR;
               end else if (any_hit) begin
                  state <= IDLE;
               end else begin
                  victim_q <= victim_pick;
                  state    <= victim_dirty ? WB : FILL;
               end
            end
            WB: begin
               if (mem_ack) begin
                  if (mem_err) begin
                     beat_cnt <= '0;
                     state    <= ERROR;
                  end else if (last_beat) begin
                     beat_cnt <= '0;
                     state    <= FILL;
                  end else begin
                     beat_cnt <= beat_cnt + BEAT_W'(1);
                  end
               end
            end
            FILL: begin
               if (mem_ack) begin
                  if (mem_err) begin
                     beat_cnt <= '0;
                     state    <= ERROR;
                  end else if (last_beat) begin
                     beat_cnt <= '0;
                     replay   <= 1'b1;
                     state    <= LOOKUP;
                  end else begin
                     beat_cnt <= beat_cnt + BEAT_W'(1);
                  end
               end
            end
            ERROR: begin
               state <= IDLE;
            end
            default: begin
               beat_cnt <= '0;
               state    <= ERROR;
            end
         endcase
      end
   end

   // Memory request levels and beat index follow the registered state directly.
   assign mem_write = (state == WB);
   assign mem_read  = (state == FILL);
   assign beat_idx  = beat_cnt;

   // Array, LRU and CPU strobes for the current state and beat.
   always_comb begin
      cpu_mem_valid = 1'b0;
      cpu_err       = 1'b0;
      lru_load      = 1'b0;
      way_sel       = victim_q;
      load_tag      = '0;
      load_line     = '0;
      load_bytes    = '0;
      set_valid     = '0;
      write_valid   = '0;
      set_dirty     = '0;
      write_dirty   = '0;
      case (state)
         LOOKUP: begin
            if (single_hit) begin
               cpu_mem_valid = 1'b1;
               lru_load      = 1'b1;
               way_sel       = hit_idx;
               if (op == OP_WRITE) begin
                  load_bytes  = hit_way;
                  set_dirty   = hit_way;
                  write_dirty = hit_way;
               end
            end
         end
         FILL: begin
            if (mem_ack) begin
               if (mem_err) begin
                  // Partial line is unusable: clear the victim's valid bit.
                  write_valid = victim_oh;
               end else begin
                  load_line = victim_oh;
                  if (last_beat) begin
                     load_tag    = victim_oh;
                     set_valid   = victim_oh;
                     write_valid = victim_oh;
                     write_dirty = victim_oh;
                  end
               end
            end
         end
         ERROR: begin
            cpu_err = 1'b1;
         end
         default: begin
         end
      endcase
   end

`ifdef CACHE_PERF_CNT_EN
   // Performance counters; replayed lookups after a fill are not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         wb_cnt   <= '0;
      end else if (state == LOOKUP) begin
         if (!replay && single_hit) hit_cnt <= hit_cnt + 32'd1;
         if (!replay && !any_hit)   miss_cnt <= miss_cnt + 32'd1;
         if (!any_hit && victim_dirty) wb_cnt <= wb_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed, table-driven bench for cache_ctrl_nway (WAYS=4, LINE_BEATS=4).
// Each table row is one clock: inputs, then the full expected output vector.
module tb_cache_ctrl_nway;

   localparam logic [3:0] NONE = 4'b0000;
   localparam logic [3:0] ALL  = 4'b1111;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpu_read, cpu_write;
   logic [3:0] hit_way, is_valid, is_dirty;
   logic [1:0] lru_victim;
   logic       mem_ack, mem_err;
   logic       cpu_mem_valid, cpu_err, lru_load;
   logic [1:0] way_sel;
   logic [3:0] load_tag, load_line, load_bytes;
   logic [3:0] set_valid, write_valid, set_dirty, write_dirty;
   logic       mem_read, mem_write;
   logic [1:0] beat_idx;
`ifdef CACHE_PERF_CNT_EN
   logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cache_ctrl_nway #(
      .WAYS       (4),
      .LINE_BEATS (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_read      (cpu_read),
      .cpu_write     (cpu_write),
      .hit_way       (hit_way),
      .is_valid      (is_valid),
      .is_dirty      (is_dirty),
      .lru_victim    (lru_victim),
      .mem_ack       (mem_ack),
      .mem_err       (mem_err),
      .cpu_mem_valid (cpu_mem_valid),
      .cpu_err       (cpu_err),
      .lru_load      (lru_load),
      .way_sel       (way_sel),
      .load_tag      (load_tag),
      .load_line     (load_line),
      .load_bytes    (load_bytes),
      .set_valid     (set_valid),
      .write_valid   (write_valid),
      .set_dirty     (set_dirty),
      .write_dirty   (write_dirty),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
`ifdef CACHE_PERF_CNT_EN
      .hit_cnt       (hit_cnt),
      .miss_cnt      (miss_cnt),
      .wb_cnt        (wb_cnt),
`endif
      .beat_idx      (beat_idx)
   );

   typedef struct {
      string      name;
      logic       rd;
      logic       wr;
      logic [3:0] hit;
      logic [3:0] vld;
      logic [3:0] drt;
      logic [1:0] lru;
      logic       ack;
      logic       err;
      logic [36:0] exp;
   } vec_t;

   vec_t vecs[$];

   // {valid, err, lru_load, way_sel, tag, line, bytes, set_v, wr_v, set_d, wr_d, mem_rd, mem_wr, beat}
   function automatic logic [36:0] pk(input logic v, input logic er, input logic ll,
                                      input logic [1:0] ws, input logic [3:0] tg,
                                      input logic [3:0] ln, input logic [3:0] by,
                                      input logic [3:0] sv, input logic [3:0] wv,
                                      input logic [3:0] sd, input logic [3:0] wd,
                                      input logic mr, input logic mw, input logic [1:0] bi);
      return {v, er, ll, ws, tg, ln, by, sv, wv, sd, wd, mr, mw, bi};
   endfunction

   function automatic logic [3:0] oh(input logic [1:0] w);
      return 4'b0001 << w;
   endfunction

   function automatic logic [36:0] quiet(input logic [1:0] ws);
      return pk(1'b0, 1'b0, 1'b0, ws, NONE, NONE, NONE, NONE, NONE, NONE, NONE, 1'b0, 1'b0, 2'd0);
   endfunction

   function automatic logic [36:0] hit_rd(input logic [1:0] ws);
      return pk(1'b1, 1'b0, 1'b1, ws, NONE, NONE, NONE, NONE, NONE, NONE, NONE, 1'b0, 1'b0, 2'd0);
   endfunction

   function automatic logic [36:0] hit_wr(input logic [1:0] ws);
      return pk(1'b1, 1'b0, 1'b1, ws, NONE, NONE, oh(ws), NONE, NONE, oh(ws), oh(ws), 1'b0, 1'b0, 2'd0);
   endfunction

   function automatic logic [36:0] wbb(input logic [1:0] ws, input logic [1:0] bi);
      return pk(1'b0, 1'b0, 1'b0, ws, NONE, NONE, NONE, NONE, NONE, NONE, NONE, 1'b0, 1'b1, bi);
   endfunction

   function automatic logic [36:0] fillb(input logic [1:0] ws, input logic [1:0] bi, input logic ack);
      return pk(1'b0, 1'b0, 1'b0, ws, NONE, ack ? oh(ws) : NONE, NONE, NONE, NONE, NONE, NONE,
                1'b1, 1'b0, bi);
   endfunction

   function automatic logic [36:0] filllast(input logic [1:0] ws);
      return pk(1'b0, 1'b0, 1'b0, ws, oh(ws), oh(ws), NONE, oh(ws), oh(ws), NONE, oh(ws),
                1'b1, 1'b0, 2'd3);
   endfunction

   function automatic logic [36:0] fillerr(input logic [1:0] ws, input logic [1:0] bi);
      return pk(1'b0, 1'b0, 1'b0, ws, NONE, NONE, NONE, NONE, oh(ws), NONE, NONE, 1'b1, 1'b0, bi);
   endfunction

   function automatic logic [36:0] errp(input logic [1:0] ws);
      return pk(1'b0, 1'b1, 1'b0, ws, NONE, NONE, NONE, NONE, NONE, NONE, NONE, 1'b0, 1'b0, 2'd0);
   endfunction

   function automatic logic [36:0] obs();
      return {cpu_mem_valid, cpu_err, lru_load, way_sel, load_tag, load_line, load_bytes,
              set_valid, write_valid, set_dirty, write_dirty, mem_read, mem_write, beat_idx};
   endfunction

   task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input string n, input logic rd, input logic wr, input logic [3:0] hit,
                      input logic [3:0] vld, input logic [3:0] drt, input logic [1:0] lru,
                      input logic ack, input logic err, input logic [36:0] exp);
      vec_t v;
      v.name = n; v.rd = rd; v.wr = wr; v.hit = hit; v.vld = vld; v.drt = drt;
      v.lru = lru; v.ack = ack; v.err = err; v.exp = exp;
      vecs.push_back(v);
   endtask

   // Called just after a rising edge: drive, settle, compare, advance one clock.
   task automatic run_cycle(input vec_t v);
      cpu_read   = v.rd;
      cpu_write  = v.wr;
      hit_way    = v.hit;
      is_valid   = v.vld;
      is_dirty   = v.drt;
      lru_victim = v.lru;
      mem_ack    = v.ack;
      mem_err    = v.err;
      #1;
      check(v.name, obs(), v.exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      cpu_read = 1'b0; cpu_write = 1'b0; hit_way = NONE; is_valid = NONE;
      is_dirty = NONE; lru_victim = 2'd0; mem_ack = 1'b0; mem_err = 1'b0;

      //  name            rd    wr    hit      vld      drt      lru    ack   err   expected
      add("idle",        1'b0, 1'b0, NONE,    ALL,     NONE,    2'd0, 1'b0, 1'b0, quiet(2'd0));
      // read hit on way 2
      add("t1_req",      1'b1, 1'b0, 4'b0100, ALL,     NONE,    2'd0, 1'b0, 1'b0, quiet(2'd0));
      add("t1_hit",      1'b1, 1'b0, 4'b0100, ALL,     NONE,    2'd0, 1'b0, 1'b0, hit_rd(2'd2));
      add("t1_after",    1'b0, 1'b0, NONE,    ALL,     NONE,    2'd0, 1'b0, 1'b0, quiet(2'd0));
      // read miss, way 1 invalid, gapped acks
      add("t2_req",      1'b1, 1'b0, NONE,    4'b1101, NONE,    2'd3, 1'b0, 1'b0, quiet(2'd0));
      add("t2_miss",     1'b1, 1'b0, NONE,    4'b1101, NONE,    2'd3, 1'b0, 1'b0, quiet(2'd0));
      add("t2_f0_wait",  1'b1, 1'b0, NONE,    4'b1101, NONE,    2'd3, 1'b0, 1'b0, fillb(2'd1, 2'd0, 1'b0));
      add("t2_f0",       1'b1, 1'b0, NONE,    4'b1101, NONE,    2'd3, 1'b1, 1'b0, fillb(2'd1, 2'd0, 1'b1));
      add("t2_f1_wait",  1'b1, 1'b0, NONE,    4'b1101, NONE,    2'd3, 1'b0, 1'b0, fillb(2'd1, 2'd1, 1'b0));
      add("t2_f1",       1'b1, 1'b0, NONE,    4'b1101, NONE,    2'd3, 1'b1, 1'b0, fillb(2'd1, 2'd1, 1'b1));
      add("t2_f2",       1'b1, 1'b0, NONE,    4'b1101, NONE,    2'd3, 1'b1, 1'b0, fillb(2'd1, 2'd2, 1'b1));
      add("t2_f3_wait",  1'b1, 1'b0, NONE,    4'b1101, NONE,    2'd3, 1'b0, 1'b0, fillb(2'd1, 2'd3, 1'b0));
      add("t2_f3_last",  1'b1, 1'b0, NONE,    4'b1101, NONE,    2'd3, 1'b1, 1'b0, filllast(2'd1));
      add("t2_replay",   1'b1, 1'b0, 4'b0010, ALL,     NONE,    2'd3, 1'b0, 1'b0, hit_rd(2'd1));
      // write miss, all valid, dirty LRU victim 3
      add("t3_req",      1'b0, 1'b1, NONE,    ALL,     4'b1000, 2'd3, 1'b0, 1'b0, quiet(2'd1));
      add("t3_miss",     1'b0, 1'b1, NONE,    ALL,     4'b1000, 2'd3, 1'b0, 1'b0, quiet(2'd1));
      add("t3_wb0_wait", 1'b0, 1'b1, NONE,    ALL,     4'b1000, 2'd3, 1'b0, 1'b0, wbb(2'd3, 2'd0));
      add("t3_wb0",      1'b0, 1'b1, NONE,    ALL,     4'b1000, 2'd3, 1'b1, 1'b0, wbb(2'd3, 2'd0));
      add("t3_wb1",      1'b0, 1'b1, NONE,    ALL,     4'b1000, 2'd3, 1'b1, 1'b0, wbb(2'd3, 2'd1));
      add("t3_wb2",      1'b0, 1'b1, NONE,    ALL,     4'b1000, 2'd3, 1'b1, 1'b0, wbb(2'd3, 2'd2));
      add("t3_wb3_wait", 1'b0, 1'b1, NONE,    ALL,     4'b1000, 2'd3, 1'b0, 1'b0, wbb(2'd3, 2'd3));
      add("t3_wb3",      1'b0, 1'b1, NONE,    ALL,     4'b1000, 2'd3, 1'b1, 1'b0, wbb(2'd3, 2'd3));
      add("t3_f0",       1'b0, 1'b1, NONE,    ALL,     4'b1000, 2'd3, 1'b1, 1'b0, fillb(2'd3, 2'd0, 1'b1));
      add("t3_f1",       1'b0, 1'b1, NONE,    ALL,     4'b1000, 2'd3, 1'b1, 1'b0, fillb(2'd3, 2'd1, 1'b1));
      add("t3_f2",       1'b0, 1'b1, NONE,    ALL,     4'b1000, 2'd3, 1'b1, 1'b0, fillb(2'd3, 2'd2, 1'b1));
      add("t3_f3_last",  1'b0, 1'b1, NONE,    ALL,     4'b1000, 2'd3, 1'b1, 1'b0, filllast(2'd3));
      add("t3_replay",   1'b0, 1'b1, 4'b1000, ALL,     NONE,    2'd3, 1'b0, 1'b0, hit_wr(2'd3));
      // read miss, clean victim 2, error on fill beat 2
      add("t4_req",      1'b1, 1'b0, NONE,    ALL,     NONE,    2'd2, 1'b0, 1'b0, quiet(2'd3));
      add("t4_miss",     1'b1, 1'b0, NONE,    ALL,     NONE,    2'd2, 1'b0, 1'b0, quiet(2'd3));
      add("t4_f0",       1'b1, 1'b0, NONE,    ALL,     NONE,    2'd2, 1'b1, 1'b0, fillb(2'd2, 2'd0, 1'b1));
      add("t4_f1",       1'b1, 1'b0, NONE,    ALL,     NONE,    2'd2, 1'b1, 1'b0, fillb(2'd2, 2'd1, 1'b1));
      add("t4_f2_err",   1'b1, 1'b0, NONE,    ALL,     NONE,    2'd2, 1'b1, 1'b1, fillerr(2'd2, 2'd2));
      add("t4_cpu_err",  1'b1, 1'b0, NONE,    ALL,     NONE,    2'd2, 1'b0, 1'b0, errp(2'd2));
      add("t4_idle",     1'b0, 1'b0, NONE,    ALL,     NONE,    2'd2, 1'b0, 1'b0, quiet(2'd2));
      // multi-hot hit vector
      add("t5_req",      1'b1, 1'b0, 4'b0110, ALL,     NONE,    2'd0, 1'b0, 1'b0, quiet(2'd2));
      add("t5_multihit", 1'b1, 1'b0, 4'b0110, ALL,     NONE,    2'd0, 1'b0, 1'b0, quiet(2'd2));
      add("t5_cpu_err",  1'b1, 1'b0, 4'b0110, ALL,     NONE,    2'd0, 1'b0, 1'b0, errp(2'd2));
      add("t5_idle",     1'b0, 1'b0, NONE,    ALL,     NONE,    2'd0, 1'b0, 1'b0, quiet(2'd2));

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("reset_outputs", obs(), '0);
`ifdef CACHE_PERF_CNT_EN
      check("reset_hit_cnt", {5'd0, hit_cnt}, 37'd0);
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         run_cycle(vecs[i]);
      end

`ifdef CACHE_PERF_CNT_EN
      // 1 hit (t1), 3 misses (t2, t3, t4), 1 write-back (t3); replays and multi-hit not counted.
      check("hit_cnt",  {5'd0, hit_cnt},  37'd1);
      check("miss_cnt", {5'd0, miss_cnt}, 37'd3);
      check("wb_cnt",   {5'd0, wb_cnt},   37'd1);
`endif

      // Reset during write-back beat 1 aborts the transfer on the next edge.
      begin
         vec_t v;
         v.hit = NONE; v.vld = ALL; v.drt = 4'b1000; v.lru = 2'd3; v.err = 1'b0;
         v.rd = 1'b0; v.wr = 1'b1;
         v.name = "rst_req";   v.ack = 1'b0; v.exp = quiet(2'd2);     run_cycle(v);
         v.name = "rst_miss";  v.ack = 1'b0; v.exp = quiet(2'd2);     run_cycle(v);
         v.name = "rst_wb0";   v.ack = 1'b1; v.exp = wbb(2'd3, 2'd0); run_cycle(v);
         rst = 1'b1;
         v.name = "rst_wb1";   v.ack = 1'b0; v.exp = wbb(2'd3, 2'd1); run_cycle(v);
         rst = 1'b0;
         v.wr = 1'b0;
         v.name = "rst_abort"; v.ack = 1'b0; v.exp = quiet(2'd0);     run_cycle(v);
`ifdef CACHE_PERF_CNT_EN
         check("rst_miss_cnt", {5'd0, miss_cnt}, 37'd0);
         check("rst_wb_cnt",   {5'd0, wb_cnt},   37'd0);
`endif
         // Controller is usable again straight after the abort.
         v.rd = 1'b1; v.hit = 4'b0001; v.drt = NONE;
         v.name = "post_req";  v.exp = quiet(2'd0);  run_cycle(v);
         v.name = "post_hit";  v.exp = hit_rd(2'd0); run_cycle(v);
         v.rd = 1'b0; v.hit = NONE;
         v.name = "post_idle"; v.exp = quiet(2'd0);  run_cycle(v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
